// File: rtl/npu_tile_sequencer_pkg.sv
// Shared types and constants for the NPU tile sequencer: the FSM state
// encoding, the bit layout of the header word and the flat-bus element index.
package npu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IN,
    LOAD_WT,
    START,
    WAIT_CALC,
    ACT,
    SEND
  } seq_state_e;

  // Header word layout: tile count, layer type flag, activation enable.
  localparam int HDR_N_LSB     = 0;
  localparam int HDR_N_MSB     = 7;
  localparam int HDR_LAYER_BIT = 8;
  localparam int HDR_ACT_BIT   = 9;

  // Position of element (r,c) on a flat operand bus, in elements.
  // Multiply by the element width to get the bit offset.
  function automatic int elem_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/npu_tile_sequencer.sv
// NPU tile sequencer: takes a header word, then one input word and one weight
// word per tile from the SPI slave, drives the PE array operands as flat
// buses and steps through start, calculator completion, optional activation
// and result return to SPI.
// Optional build macro: NPU_SEQ_WATCHDOG_EN adds a calculator watchdog that
// aborts to IDLE with error set after TIMEOUT_CYCLES cycles in WAIT_CALC.
module npu_tile_sequencer
  import npu_seq_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int ELEM_W         = 16,
  parameter int RES_W          = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int WORD_W        = ROWS * COLS * ELEM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en_frm_spi,
  input  logic [WORD_W-1:0] data_in_from_spi,
  input  logic              soft_reset,
  input  logic              calculator_valid,
  input  logic              neuron_ready,
  input  logic [RES_W-1:0]  neuron_result_in,
  input  logic              transmitted,
  output logic              start,
  output logic              layer_type,
  output logic              add_activation,
  output logic [WORD_W-1:0] input_flat,
  output logic [WORD_W-1:0] weight_flat,
  output logic [RES_W-1:0]  neuron_data,
  output logic              load_to_spi,
  output logic              busy,
  output logic [7:0]        tile_idx,
  output logic              error
);

  seq_state_e state;
  logic [7:0] n_tiles;
  logic       act_en;

`ifdef NPU_SEQ_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`else
  // TIMEOUT_CYCLES has no effect without the watchdog; this empty block only
  // keeps the parameter referenced.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // Sequencer FSM with registered control outputs and operand/result capture.
  always_ff @(posedge clk) begin
    if (reset || soft_reset) begin
      state          <= IDLE;
      n_tiles        <= '0;
      act_en         <= 1'b0;
      start          <= 1'b0;
      layer_type     <= 1'b0;
      add_activation <= 1'b0;
      input_flat     <= '0;
      weight_flat    <= '0;
      neuron_data    <= '0;
      load_to_spi    <= 1'b0;
      busy           <= 1'b0;
      tile_idx       <= '0;
      error          <= 1'b0;
`ifdef NPU_SEQ_WATCHDOG_EN
      wd_cnt         <= '0;
`endif
    end else begin
      // A word arriving while the sequencer is not loading is dropped.
      if (write_en_frm_spi &&
          (state == START || state == WAIT_CALC || state == ACT || state == SEND))
        error <= 1'b1;

      case (state)
        IDLE: begin
          if (write_en_frm_spi) begin
            n_tiles    <= data_in_from_spi[HDR_N_MSB:HDR_N_LSB];
            layer_type <= data_in_from_spi[HDR_LAYER_BIT];
            act_en     <= data_in_from_spi[HDR_ACT_BIT];
            if (data_in_from_spi[HDR_N_MSB:HDR_N_LSB] == 8'd0) begin
              error <= 1'b1;
            end else begin
              tile_idx <= 8'd0;
              busy     <= 1'b1;
              state    <= LOAD_IN;
            end
          end
        end

        LOAD_IN: begin
          if (write_en_frm_spi) begin
            input_flat <= data_in_from_spi;
            state      <= LOAD_WT;
          end
        end

        LOAD_WT: begin
          if (write_en_frm_spi) begin
            weight_flat <= data_in_from_spi;
            start       <= 1'b1;
            state       <= START;
          end
        end

        START: begin
          start <= 1'b0;
`ifdef NPU_SEQ_WATCHDOG_EN
          wd_cnt <= '0;
`endif
          state <= WAIT_CALC;
        end

        WAIT_CALC: begin
          if (calculator_valid) begin
            if (tile_idx < n_tiles - 8'd1) begin
              tile_idx <= tile_idx + 8'd1;
              state    <= LOAD_IN;
            end else if (act_en) begin
              add_activation <= 1'b1;
              state          <= ACT;
            end else begin
              neuron_data <= neuron_result_in;
              load_to_spi <= 1'b1;
              state       <= SEND;
            end
          end
`ifdef NPU_SEQ_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end

        ACT: begin
          if (neuron_ready) begin
            neuron_data    <= neuron_result_in;
            add_activation <= 1'b0;
            load_to_spi    <= 1'b1;
            state          <= SEND;
          end
        end

        SEND: begin
          if (transmitted) begin
            load_to_spi <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          start          <= 1'b0;
          add_activation <= 1'b0;
          load_to_spi    <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
